mcpu_ps2_keyboard: RTL and testbench
====================================

// Module: mcpu_ps2_keyboard
// PURPOSE
//  Upstream input stage for the mcpu top level: receives PS/2 keyboard frames,
//  checks them, and buffers the scan codes in a small FIFO.
//  The FIFO head drives the CPU keycode input, which the ALU reads as its Y operand.
//  The CPU consumes a byte by strobing key_pop, decoded from a write into the
//  unused 2'b11 address region.
// PARAMETERS
//  FIFO_AW       3     log2 of FIFO depth (depth = 8)
//  SYNC_STAGES   2     number of synchroniser flops on ps2_clk and ps2_data (>=2)
//  TIMEOUT_W     12    width of the frame watchdog counter; timeout = 2**TIMEOUT_W-1 clk
// PORTS
//  clk        in   1   system clock
//  reset      in   1   asynchronous, active-low reset (0 = reset)
//  ps2_clk    in   1   raw PS/2 clock pin, asynchronous to clk
//  ps2_data   in   1   raw PS/2 data pin, asynchronous to clk
//  key_pop    in   1   1-cycle strobe: discard the FIFO head
//  keycode    out  8   FIFO head when key_valid=1, else 8'h00
//  key_valid  out  1   FIFO not empty
//  overflow   out  1   sticky flag: a byte was dropped because the FIFO was full
//  frame_err  out  1   1-cycle pulse on a parity, start, stop or timeout error
// BEHAVIOUR
//  Reset (reset=0, async): FSM=IDLE, FIFO empty, bit/shift/watchdog counters cleared.
//   All outputs are 0, including keycode=8'h00.
//   Synchroniser flops reset to 1 (idle bus).
//  Sampling: ps2_clk and ps2_data each pass through SYNC_STAGES flops.
//   A falling edge (fe) is a synced ps2_clk sample of 1 followed by 0.
//   Data is sampled only in the cycle fe is asserted.
//  FSM (advances only on fe, except for the watchdog):
//   IDLE  : data=0 -> DATA, bitcnt=0; data=1 -> stay in IDLE, no error.
//   DATA  : shift in LSB first; after the 8th bit -> PARITY.
//   PARITY: capture the parity bit -> STOP.
//   STOP  : go to IDLE. If stop=1 and odd parity holds over data+parity,
//           push the byte; otherwise pulse frame_err and drop the byte.
//  Watchdog: counter clears on every fe and holds at 0 in IDLE.
//   In any non-IDLE state, reaching all-ones -> IDLE, frame_err pulse,
//   partial byte discarded.
//  Latency: the push happens in the fe cycle of the stop bit; keycode and
//   key_valid update on the next clk edge. Worst case from the pin edge:
//   SYNC_STAGES+2 clk.
//  FIFO: show-ahead, registered pointers, count width FIFO_AW+1.
//   Pointers wrap modulo depth.
//   pop with empty FIFO: ignored.
//   push with full FIFO and no pop: byte dropped, overflow<=1.
//   push and pop together, FIFO full: both happen, count unchanged, no overflow.
//   push and pop together, FIFO empty: pop ignored, push accepted.
//   overflow clears on the first accepted key_pop; otherwise it holds.
//  frame_err is registered and high for exactly one clk per error event.
//  Reset mid-frame: the partial frame is lost. After reset is released, the FSM
//   resyncs on the next start bit (data=0 at fe); no error is reported for the
//   abandoned frame.
// TESTING
//  1 Send frame 0x1C (bits 0,0,1,1,1,0,0,0; parity 0; stop 1)
//    -> keycode=8'h1C, key_valid=1 within SYNC_STAGES+2 clk of the last edge.
//  2 Pulse key_pop with 0x1C queued -> next cycle keycode=8'h00, key_valid=0.
//    Pulse key_pop again -> no change.
//  3 Send 0x1C with parity=1 -> frame_err high for 1 clk, key_valid stays 0.
//    Repeat with stop=0 -> same response.
//  4 Send 9 valid bytes 0x01..0x09 with no pops -> 0x01..0x08 stored, overflow=1.
//    Popping 8 times returns 0x01..0x08 in order; overflow clears on the first pop.
//  5 Send start + 3 data bits, then idle -> after 4095 clk, frame_err pulses and
//    the FSM is in IDLE. A following valid 0x5A frame is received correctly.
//  6 Assert reset mid-frame with 2 bytes queued -> all outputs 0, FIFO empty.
//    After release, a valid 0x29 frame yields keycode=8'h29.
//    Also cover: pop and push in the same cycle with the FIFO full -> count stays 8,
//    no overflow.

Source files
------------

// File: rtl/mcpu_ps2_keyboard.sv
// PS/2 keyboard receiver: synchronise pins, deframe 11-bit frames, queue scan codes in a show-ahead FIFO.
// Latency: stop-bit pin edge to keycode/key_valid update is at most SYNC_STAGES+2 clk.
// Backpressure: none upstream (PS/2 cannot be stalled); a byte arriving with the FIFO full is dropped and overflow sets.
// Ports: clk/reset (async, active-low), ps2_clk/ps2_data raw pins, key_pop head-discard strobe,
//        keycode (head or 8'h00), key_valid (not empty), overflow (sticky), frame_err (1-clk pulse).
module mcpu_ps2_keyboard #(
   parameter int FIFO_AW     = 3,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT_W   = 12
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       key_pop,
   output logic [7:0] keycode,
   output logic       key_valid,
   output logic       overflow,
   output logic       frame_err
);

   localparam int DEPTH = 1 << FIFO_AW;

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

   // ---------------- pin synchronisers and falling-edge detect ----------------
   logic [SYNC_STAGES-1:0] r_clk_sync;
   logic [SYNC_STAGES-1:0] r_dat_sync;
   logic                   r_clk_prev;
   logic                   w_clk_s;
   logic                   w_dat_s;
   logic                   w_fe;

   // Synchronisers reset to 1 so a released reset never looks like a falling edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_clk_sync <= '1;
         r_dat_sync <= '1;
         r_clk_prev <= 1'b1;
      end else begin
         r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
         r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ps2_data};
         r_clk_prev <= w_clk_s;
      end
   end

   assign w_clk_s = r_clk_sync[SYNC_STAGES-1];
   assign w_dat_s = r_dat_sync[SYNC_STAGES-1];
   assign w_fe    = r_clk_prev & ~w_clk_s;

   // ---------------- frame FSM ----------------
   state_t               r_state, w_state_nxt;
   logic [2:0]           r_bitcnt, w_bitcnt_nxt;
   logic [7:0]           r_shift, w_shift_nxt;
   logic                 r_par, w_par_nxt;
   logic [TIMEOUT_W-1:0] r_wdog, w_wdog_nxt;
   logic                 r_frame_err;
   logic                 w_push;
   logic                 w_err;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_bitcnt    <= '0;
         r_shift     <= '0;
         r_par       <= 1'b0;
         r_wdog      <= '0;
         r_frame_err <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_bitcnt    <= w_bitcnt_nxt;
         r_shift     <= w_shift_nxt;
         r_par       <= w_par_nxt;
         r_wdog      <= w_wdog_nxt;
         r_frame_err <= w_err;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_bitcnt_nxt = r_bitcnt;
      w_shift_nxt  = r_shift;
      w_par_nxt    = r_par;
      w_wdog_nxt   = r_wdog;
      w_push       = 1'b0;
      w_err        = 1'b0;
      if (w_fe) begin
         w_wdog_nxt = '0;
         case (r_state)
            S_IDLE: begin
               // A high data bit at an edge is line noise, not a start bit.
               if (!w_dat_s) begin
                  w_state_nxt  = S_DATA;
                  w_bitcnt_nxt = '0;
               end
            end
            S_DATA: begin
               w_shift_nxt  = {w_dat_s, r_shift[7:1]};
               w_bitcnt_nxt = r_bitcnt + 3'd1;
               if (r_bitcnt == 3'd7) w_state_nxt = S_PARITY;
            end
            S_PARITY: begin
               w_par_nxt   = w_dat_s;
               w_state_nxt = S_STOP;
            end
            S_STOP: begin
               w_state_nxt = S_IDLE;
               // Odd parity: data plus parity bit must carry an odd number of ones.
               if (w_dat_s && (^{r_shift, r_par})) w_push = 1'b1;
               else                                 w_err  = 1'b1;
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end else if (r_state == S_IDLE) begin
         w_wdog_nxt = '0;
      end else if (&r_wdog) begin
         // Keyboard stopped clocking mid-frame: abandon it and re-arm for a start bit.
         w_state_nxt = S_IDLE;
         w_wdog_nxt  = '0;
         w_err       = 1'b1;
      end else begin
         w_wdog_nxt = r_wdog + TIMEOUT_W'(1);
      end
   end

   assign frame_err = r_frame_err;

   // ---------------- show-ahead FIFO ----------------
   logic [7:0]         r_mem [DEPTH];
   logic [FIFO_AW-1:0] r_wptr, r_rptr;
   logic [FIFO_AW:0]   r_count;
   logic               r_overflow;
   logic               w_empty, w_full, w_pop_ok, w_push_ok;

   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == (FIFO_AW+1)'(DEPTH));
   assign w_pop_ok  = key_pop & ~w_empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
   assign w_push_ok = w_push & (~w_full | w_pop_ok);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push_ok) r_wptr <= r_wptr + FIFO_AW'(1);
         if (w_pop_ok)  r_rptr <= r_rptr + FIFO_AW'(1);
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + (FIFO_AW+1)'(1);
            2'b01:   r_count <= r_count - (FIFO_AW+1)'(1);
            default: r_count <= r_count;
         endcase
         if (w_push && !w_push_ok) r_overflow <= 1'b1;
         else if (w_pop_ok)        r_overflow <= 1'b0;
      end
   end

   // Storage needs no reset: the head is masked to 8'h00 whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wptr] <= r_shift;
   end

   assign key_valid = ~w_empty;
   assign keycode   = w_empty ? 8'h00 : r_mem[r_rptr];
   assign overflow  = r_overflow;

endmodule

// File: tb/tb_mcpu_ps2_keyboard.sv
// Self-checking bench for mcpu_ps2_keyboard: table vectors, hand-written corner sequences, random frames vs. a queue model.
// Latency: inputs driven on falling clk edges, outputs sampled on falling clk edges.
// Backpressure: the bench pops the FIFO through key_pop as the model dictates.
module tb_mcpu_ps2_keyboard;

   localparam int SYNC = 2;

   logic       clk = 1'b0;
   logic       reset;
   logic       ps2_clk;
   logic       ps2_data;
   logic       key_pop;
   logic [7:0] keycode;
   logic       key_valid;
   logic       overflow;
   logic       frame_err;

   int checks = 0;
   int errors = 0;
   int err_cnt = 0;

   // Reference model: plain queue of accepted bytes plus sticky overflow bit.
   logic [7:0] q[$];
   logic       ovf;

   mcpu_ps2_keyboard #(.FIFO_AW(3), .SYNC_STAGES(SYNC), .TIMEOUT_W(12)) dut (
      .clk      (clk),
      .reset    (reset),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .key_pop  (key_pop),
      .keycode  (keycode),
      .key_valid(key_valid),
      .overflow (overflow),
      .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (frame_err === 1'b1) err_cnt++;

   initial begin
      #900000;
      $display("FAIL global_timeout: simulation did not finish, required finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1);
   end

   typedef struct {
      logic [7:0] code;
      logic       par;
      logic       stp;
      logic       exp_valid;
      logic [7:0] exp_key;
      int         exp_err;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic good_par(input logic [7:0] b);
      return ~^b;
   endfunction

   // Model of one complete frame; returns the number of error pulses expected.
   function automatic int model_frame(input logic [7:0] b, input logic par, input logic stp);
      logic ok;
      ok = stp && ((^b ^ par) == 1'b1);
      if (!ok) return 1;
      if (q.size() < 8) q.push_back(b);
      else ovf = 1'b1;
      return 0;
   endfunction

   function automatic void model_pop();
      if (q.size() > 0) begin
         void'(q.pop_front());
         ovf = 1'b0;
      end
   endfunction

   task automatic cmp_model(input string tag);
      chk({tag, "_valid"}, key_valid, q.size() > 0);
      chk({tag, "_key"}, keycode, (q.size() > 0) ? q[0] : 8'h00);
      chk({tag, "_ovf"}, overflow, ovf);
   endtask

   // Drive nbits bits of a frame; optionally strobe key_pop in the push cycle of the last bit.
   task automatic send_frame(input logic [7:0] b, input logic par, input logic stp,
                             input int nbits, input bit pop_sync);
      logic [10:0] bits;
      bits = {stp, par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk); ps2_data = bits[i];
         repeat (3) @(negedge clk);
         ps2_clk = 1'b0;
         for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (pop_sync && i == nbits - 1) begin
               if (k == 2) key_pop = 1'b1;
               if (k == 3) key_pop = 1'b0;
            end
         end
         ps2_clk = 1'b1;
      end
      @(negedge clk); ps2_data = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic pop();
      @(negedge clk); key_pop = 1'b1;
      @(negedge clk); key_pop = 1'b0;
      model_pop();
   endtask

   vec_t vecs[8];

   initial begin
      int e0;
      int ee;
      logic [7:0] b;
      logic       p, s;
      int         r;

      vecs[0] = '{8'h1C, 1'b0, 1'b1, 1'b1, 8'h1C, 0};
      vecs[1] = '{8'h1C, 1'b1, 1'b1, 1'b0, 8'h00, 1};
      vecs[2] = '{8'h1C, 1'b0, 1'b0, 1'b0, 8'h00, 1};
      vecs[3] = '{8'h5A, 1'b1, 1'b1, 1'b1, 8'h5A, 0};
      vecs[4] = '{8'h5A, 1'b0, 1'b1, 1'b0, 8'h00, 1};
      vecs[5] = '{8'hFF, 1'b1, 1'b1, 1'b1, 8'hFF, 0};
      vecs[6] = '{8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 0};
      vecs[7] = '{8'h80, 1'b0, 1'b1, 1'b1, 8'h80, 0};

      reset = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; key_pop = 1'b0; ovf = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_valid", key_valid, 1'b0);
      chk("rst_key", keycode, 8'h00);
      chk("rst_ovf", overflow, 1'b0);
      chk("rst_err", frame_err, 1'b0);
      reset = 1'b1;
      repeat (3) @(negedge clk);

      // Latency: 0x1C with the stop-bit edge driven by hand.
      send_frame(8'h1C, 1'b0, 1'b1, 10, 1'b0);
      @(negedge clk); ps2_data = 1'b1;
      repeat (3) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (SYNC + 2) @(negedge clk);
      chk("lat_valid", key_valid, 1'b1);
      chk("lat_key", keycode, 8'h1C);
      repeat (4) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (4) @(negedge clk);
      void'(model_frame(8'h1C, 1'b0, 1'b1));

      // Pop to empty, then a pop on empty changes nothing.
      pop();
      chk("pop1_valid", key_valid, 1'b0);
      chk("pop1_key", keycode, 8'h00);
      pop();
      chk("pop2_valid", key_valid, 1'b0);
      chk("pop2_key", keycode, 8'h00);
      chk("pop2_ovf", overflow, 1'b0);

      // Table-driven single frames.
      for (int i = 0; i < 8; i++) begin
         e0 = err_cnt;
         send_frame(vecs[i].code, vecs[i].par, vecs[i].stp, 11, 1'b0);
         void'(model_frame(vecs[i].code, vecs[i].par, vecs[i].stp));
         chk($sformatf("vec%0d_valid", i), key_valid, vecs[i].exp_valid);
         chk($sformatf("vec%0d_key", i), keycode, vecs[i].exp_key);
         chk($sformatf("vec%0d_err", i), err_cnt - e0, vecs[i].exp_err);
         if (vecs[i].exp_valid) pop();
      end

      // Overflow: nine bytes, only eight kept, first pop clears overflow.
      for (int i = 1; i <= 9; i++) begin
         b = 8'(i);
         send_frame(b, good_par(b), 1'b1, 11, 1'b0);
         void'(model_frame(b, good_par(b), 1'b1));
      end
      chk("ovf_set", overflow, 1'b1);
      for (int i = 1; i <= 8; i++) begin
         chk($sformatf("ovf_head%0d", i), keycode, 8'(i));
         pop();
         chk($sformatf("ovf_flag%0d", i), overflow, 1'b0);
      end
      chk("ovf_empty", key_valid, 1'b0);

      // Push and pop in the same cycle with the FIFO full.
      for (int i = 0; i < 8; i++) begin
         b = 8'($urandom);
         send_frame(b, good_par(b), 1'b1, 11, 1'b0);
         void'(model_frame(b, good_par(b), 1'b1));
      end
      b = 8'hC3;
      send_frame(b, good_par(b), 1'b1, 11, 1'b1);
      model_pop();
      void'(model_frame(b, good_par(b), 1'b1));
      chk("pp_ovf", overflow, 1'b0);
      for (int i = 0; i < 8; i++) begin
         cmp_model($sformatf("pp%0d", i));
         pop();
      end
      chk("pp_empty", key_valid, 1'b0);

      // Watchdog: start + 3 data bits, then silence.
      e0 = err_cnt;
      send_frame(8'h05, 1'b0, 1'b1, 4, 1'b0);
      repeat (4000) @(negedge clk);
      chk("wd_early", err_cnt - e0, 0);
      repeat (200) @(negedge clk);
      chk("wd_pulse", err_cnt - e0, 1);
      e0 = err_cnt;
      send_frame(8'h5A, good_par(8'h5A), 1'b1, 11, 1'b0);
      void'(model_frame(8'h5A, good_par(8'h5A), 1'b1));
      chk("wd_after_key", keycode, 8'h5A);
      chk("wd_after_err", err_cnt - e0, 0);
      pop();

      // Randomized frames and pops against the queue model.
      for (int it = 0; it < 25; it++) begin
         if ($urandom_range(0, 1) == 1) begin
            pop();
            cmp_model($sformatf("rnd%0d_pop", it));
         end
         b = 8'($urandom);
         p = good_par(b);
         s = 1'b1;
         r = $urandom_range(0, 7);
         if (r == 0) p = ~p;
         if (r == 1) s = 1'b0;
         e0 = err_cnt;
         send_frame(b, p, s, 11, 1'b0);
         ee = model_frame(b, p, s);
         cmp_model($sformatf("rnd%0d", it));
         chk($sformatf("rnd%0d_err", it), err_cnt - e0, ee);
      end

      // Reset mid-frame with two bytes queued.
      while (q.size() > 0) pop();
      send_frame(8'h11, good_par(8'h11), 1'b1, 11, 1'b0);
      send_frame(8'h22, good_par(8'h22), 1'b1, 11, 1'b0);
      void'(model_frame(8'h11, good_par(8'h11), 1'b1));
      void'(model_frame(8'h22, good_par(8'h22), 1'b1));
      cmp_model("pre_rst");
      send_frame(8'h77, 1'b0, 1'b1, 5, 1'b0);
      @(negedge clk); reset = 1'b0;
      #1;
      chk("mrst_valid", key_valid, 1'b0);
      chk("mrst_key", keycode, 8'h00);
      chk("mrst_ovf", overflow, 1'b0);
      chk("mrst_err", frame_err, 1'b0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      q.delete();
      ovf = 1'b0;
      e0 = err_cnt;
      send_frame(8'h29, good_par(8'h29), 1'b1, 11, 1'b0);
      void'(model_frame(8'h29, good_par(8'h29), 1'b1));
      chk("post_rst_key", keycode, 8'h29);
      chk("post_rst_valid", key_valid, 1'b1);
      chk("post_rst_err", err_cnt - e0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
